// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, ALU/immediate selectors and decode helpers.
`timescale 1ns/1ps
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;

  function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] insn, input imm_t kind);
    logic [XLEN-1:0] imm;
    case (kind)
      IMM_S:   imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      IMM_B:   imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      IMM_U:   imm = {insn[31:12], 12'b0};
      IMM_J:   imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      default: imm = {{20{insn[31]}}, insn[31:20]};
    endcase
    return imm;
  endfunction

  // alt selects SUB/SRA; callers only raise it where the encoding allows it
  function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_if.sv
// Data-memory bus between the core (master) and dmem (slave); word addressed.
`timescale 1ns/1ps
interface riscv_if;
  import riscv_pkg::*;

  logic            we;
  logic [XLEN-3:0] word_addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;

  modport master (output we, word_addr, wdata, input rdata);
  modport slave  (input we, word_addr, wdata, output rdata);
endinterface

// File: rtl/riscv_alu.sv
// Integer ALU; shift amounts use the low five bits of b.
`timescale 1ns/1ps
module alu
  import riscv_pkg::*;
(
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_SLL:    y = a << b[4:0];
      ALU_SLT:    y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:   y = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:    y = a ^ b;
      ALU_SRL:    y = a >> b[4:0];
      ALU_SRA:    y = $signed(a) >>> b[4:0];
      ALU_OR:     y = a | b;
      ALU_AND:    y = a & b;
      ALU_PASS_B: y = b;
      default:    y = '0;
    endcase
  end
endmodule

// File: rtl/riscv_dmem.sv
// Word data memory: combinational read, write on rising edge, no reset.
`timescale 1ns/1ps
module dmem
  import riscv_pkg::*;
#(
  parameter int unsigned DMEM_SIZE = 64
) (
  input logic    clk,
  riscv_if.slave bus
);
  localparam int unsigned AW = (DMEM_SIZE > 1) ? $clog2(DMEM_SIZE) : 1;

  logic [XLEN-1:0] mem [0:DMEM_SIZE-1];
  logic [AW-1:0]   idx;

  // Word address wraps modulo the depth, which need not be a power of two
  assign idx       = AW'({2'b00, bus.word_addr} % DMEM_SIZE);
  assign bus.rdata = mem[idx];

  always_ff @(posedge clk) begin
    if (bus.we) mem[idx] <= bus.wdata;
  end
endmodule

// File: rtl/riscv_imem.sv
// Instruction ROM, combinational read; words beyond the table read as NOP.
`timescale 1ns/1ps
module imem
  import riscv_pkg::*;
#(
  parameter int unsigned IMEM_SIZE = 64
) (
  input  logic [XLEN-3:0] word_addr,
  output logic [31:0]     insn
);
  localparam int unsigned AW = (IMEM_SIZE > 1) ? $clog2(IMEM_SIZE) : 1;

  logic [31:0] tab_inst [0:IMEM_SIZE-1];

  always_comb begin
    insn = NOP_INSN;
    if ({2'b00, word_addr} < IMEM_SIZE) insn = tab_inst[word_addr[AW-1:0]];
  end
endmodule

// File: rtl/riscv_regfile.sv
// 32 x XLEN register file, two combinational reads, one synchronous write, x0 hardwired.
`timescale 1ns/1ps
module regfile
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);
  logic [XLEN-1:0] regs [0:31];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];
endmodule

// File: rtl/riscv_core.sv
// Single-cycle RV32I core with local instruction/data memories.
// Define RISCV_TRACE_EN to print a per-cycle execution trace in simulation.
`timescale 1ns/1ps
module riscv_core
  import riscv_pkg::*;
#(
  parameter int unsigned IMEM_SIZE = 64,
  parameter int unsigned DMEM_SIZE = 64
) (
  input logic clk,
  input logic rst
);
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK} wb_sel_t;

  logic [XLEN-1:0] pc, pc_next, pc_plus4;
  logic [31:0]     insn;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] rs1_data, rs2_data, imm, alu_a, alu_b, alu_y, wb_data;
  imm_t            imm_kind;
  alu_op_t         alu_op;
  wb_sel_t         wb_sel;
  logic            a_is_pc, b_is_imm, reg_we, mem_we;
  logic            is_branch, is_jal, is_jalr, take_branch;

  assign opcode   = insn[6:0];
  assign rd       = insn[11:7];
  assign funct3   = insn[14:12];
  assign rs1      = insn[19:15];
  assign rs2      = insn[24:20];
  assign pc_plus4 = pc + XLEN'(4);

  riscv_if dbus ();

  imem #(.IMEM_SIZE(IMEM_SIZE)) imem1 (
    .word_addr(pc[XLEN-1:2]),
    .insn     (insn)
  );

  dmem #(.DMEM_SIZE(DMEM_SIZE)) dmem1 (
    .clk(clk),
    .bus(dbus.slave)
  );

  regfile rf1 (
    .clk(clk),
    .rst(rst),
    .ra1(rs1),
    .ra2(rs2),
    .rd1(rs1_data),
    .rd2(rs2_data),
    .we (reg_we),
    .wa (rd),
    .wd (wb_data)
  );

  alu alu1 (
    .op(alu_op),
    .a (alu_a),
    .b (alu_b),
    .y (alu_y)
  );

  assign imm   = gen_imm(insn, imm_kind);
  assign alu_a = a_is_pc  ? pc  : rs1_data;
  assign alu_b = b_is_imm ? imm : rs2_data;

  always_comb begin
    imm_kind  = IMM_I;
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALU;
    a_is_pc   = 1'b0;
    b_is_imm  = 1'b0;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OP_LUI: begin
        imm_kind = IMM_U; alu_op = ALU_PASS_B; b_is_imm = 1'b1; reg_we = 1'b1;
      end
      OP_AUIPC: begin
        imm_kind = IMM_U; a_is_pc = 1'b1; b_is_imm = 1'b1; reg_we = 1'b1;
      end
      OP_JAL: begin
        imm_kind = IMM_J; a_is_pc = 1'b1; b_is_imm = 1'b1;
        reg_we = 1'b1; wb_sel = WB_LINK; is_jal = 1'b1;
      end
      OP_JALR: begin
        b_is_imm = 1'b1; reg_we = 1'b1; wb_sel = WB_LINK; is_jalr = 1'b1;
      end
      OP_BRANCH: begin
        imm_kind = IMM_B; a_is_pc = 1'b1; b_is_imm = 1'b1; is_branch = 1'b1;
      end
      OP_LOAD: begin
        b_is_imm = 1'b1;
        if (funct3 == F3_WORD) begin
          reg_we = 1'b1; wb_sel = WB_MEM;
        end
      end
      OP_STORE: begin
        imm_kind = IMM_S; b_is_imm = 1'b1;
        mem_we   = (funct3 == F3_WORD);
      end
      OP_IMM: begin
        b_is_imm = 1'b1; reg_we = 1'b1;
        alu_op   = alu_decode(funct3, (funct3 == 3'b101) && insn[30]);
      end
      OP_REG: begin
        reg_we = 1'b1;
        alu_op = alu_decode(funct3, insn[30] && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      default: ;
    endcase
  end

  always_comb begin
    take_branch = 1'b0;
    case (funct3)
      3'b000:  take_branch = (rs1_data == rs2_data);
      3'b001:  take_branch = (rs1_data != rs2_data);
      3'b100:  take_branch = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  take_branch = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  take_branch = (rs1_data <  rs2_data);
      3'b111:  take_branch = (rs1_data >= rs2_data);
      default: take_branch = 1'b0;
    endcase
  end

  always_comb begin
    pc_next = pc_plus4;
    if (is_jal || (is_branch && take_branch)) pc_next = alu_y;
    else if (is_jalr)                         pc_next = {alu_y[XLEN-1:1], 1'b0};
  end

  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_data = dbus.rdata;
      WB_LINK: wb_data = pc_plus4;
      default: wb_data = alu_y;
    endcase
  end

  // Stores are suppressed while reset is asserted so a coincident edge cannot write
  assign dbus.we        = mem_we & rst;
  assign dbus.word_addr = alu_y[XLEN-1:2];
  assign dbus.wdata     = rs2_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= '0;
    else      pc <= pc_next;
  end

`ifdef RISCV_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      if (reg_we && rd != '0)
        $display("%0t pc=%h insn=%h x%0d=%h", $time, pc, insn, rd, wb_data);
      else
        $display("%0t pc=%h insn=%h", $time, pc, insn);
    end
  end
`endif
endmodule

// File: tb/tb_riscv_core.sv
// Bench for riscv_core: directed programs plus random ALU/memory programs vs an ISA-level model.
`timescale 1ns/1ps
module tb_riscv_core;
  localparam int unsigned IMEM_SIZE = 64;
  localparam int unsigned DMEM_SIZE = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] prog [$];
  logic [31:0] m_imem [IMEM_SIZE];
  logic [31:0] m_mem  [DMEM_SIZE];
  logic [31:0] m_x    [32];
  logic [31:0] m_pc;
  logic [31:0] snap   [32];

  riscv_core #(.IMEM_SIZE(IMEM_SIZE), .DMEM_SIZE(DMEM_SIZE)) dut (
    .clk(clk),
    .rst(rst)
  );

  riscv_if probe ();
  assign probe.we        = dut.dbus.we;
  assign probe.word_addr = dut.dbus.word_addr;
  assign probe.wdata     = dut.dbus.wdata;
  assign probe.rdata     = dut.dbus.rdata;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] alu_model(logic [2:0] f3, logic alt, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Instruction-set model: executes one instruction at m_pc
  task automatic model_step();
    logic [31:0] i, a, b, i_imm, s_imm, b_imm, j_imm, u_imm, res, nxt;
    logic [2:0]  f3;
    logic        wr, take;
    int unsigned widx;
    widx  = m_pc >> 2;
    i     = (widx < IMEM_SIZE) ? m_imem[widx] : 32'h13;
    f3    = i[14:12];
    a     = m_x[i[19:15]];
    b     = m_x[i[24:20]];
    i_imm = {{20{i[31]}}, i[31:20]};
    s_imm = {{20{i[31]}}, i[31:25], i[11:7]};
    b_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    j_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    u_imm = {i[31:12], 12'b0};
    nxt   = m_pc + 32'd4;
    wr    = 1'b0;
    res   = '0;
    take  = 1'b0;
    case (i[6:0])
      7'h37: begin res = u_imm; wr = 1'b1; end
      7'h17: begin res = m_pc + u_imm; wr = 1'b1; end
      7'h6f: begin res = m_pc + 32'd4; wr = 1'b1; nxt = m_pc + j_imm; end
      7'h67: begin res = m_pc + 32'd4; wr = 1'b1; nxt = (a + i_imm) & 32'hFFFF_FFFE; end
      7'h63: begin
        case (f3)
          3'd0: take = (a == b);
          3'd1: take = (a != b);
          3'd4: take = ($signed(a) < $signed(b));
          3'd5: take = ($signed(a) >= $signed(b));
          3'd6: take = (a < b);
          3'd7: take = (a >= b);
          default: take = 1'b0;
        endcase
        if (take) nxt = m_pc + b_imm;
      end
      7'h03: if (f3 == 3'd2) begin res = m_mem[((a + i_imm) >> 2) % DMEM_SIZE]; wr = 1'b1; end
      7'h23: if (f3 == 3'd2) m_mem[((a + s_imm) >> 2) % DMEM_SIZE] = b;
      7'h13: begin res = alu_model(f3, (f3 == 3'd5) && i[30], a, i_imm); wr = 1'b1; end
      7'h33: begin res = alu_model(f3, i[30], a, b); wr = 1'b1; end
      default: ;
    endcase
    if (wr && i[11:7] != 5'd0) m_x[i[11:7]] = res;
    m_pc = nxt;
  endtask

  task automatic model_reset();
    m_pc = '0;
    for (int k = 0; k < 32; k++) m_x[k] = '0;
  endtask

  task automatic load_prog();
    for (int k = 0; k < IMEM_SIZE; k++) begin
      m_imem[k] = (k < prog.size()) ? prog[k] : 32'h13;
      dut.imem1.tab_inst[k] = m_imem[k];
    end
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      model_step();
      check("pc_step", dut.pc, m_pc);
    end
  endtask

  task automatic check_regs_model(input string tag);
    for (int k = 0; k < 32; k++)
      check($sformatf("%s_x%0d", tag, k), dut.rf1.regs[k], m_x[k]);
  endtask

  function automatic logic [31:0] rand_insn();
    logic [4:0]  rd, rs1, rs2, sh;
    logic [2:0]  f3;
    logic [11:0] imm;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(1, 7));
    f3  = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    sh  = 5'($urandom);
    case ($urandom_range(0, 10))
      0, 1, 2, 3: begin
        if (f3 == 3'd1)      imm = {7'h00, sh};
        else if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, sh};
        return enc_i(imm, rs1, f3, rd, 7'h13);
      end
      4, 5, 6: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                            rs2, rs1, f3, rd);
      7:       return enc_u(20'($urandom), rd, 7'h37);
      8:       return enc_u(20'($urandom), rd, 7'h17);
      9:       return enc_s(12'(4 * $urandom_range(0, 127)), rs2, 5'd0);
      default: return enc_i(12'(4 * $urandom_range(0, 127)), 5'd0, 3'b010, rd, 7'h03);
    endcase
  endfunction

  initial begin
    rst = 1'b0;
    for (int k = 0; k < DMEM_SIZE; k++) begin
      dut.dmem1.mem[k] = '0;
      m_mem[k] = '0;
    end

    prog.delete();
    prog.push_back(enc_i(12'd5,    5'd0, 3'd0, 5'd1,  7'h13));  // 0
    prog.push_back(enc_i(12'hFFD,  5'd0, 3'd0, 5'd2,  7'h13));  // 4
    prog.push_back(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));       // 8  add
    prog.push_back(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4));       // 12 sub
    prog.push_back(enc_i({7'h20, 5'd1}, 5'd2, 3'd5, 5'd5, 7'h13)); // 16 srai
    prog.push_back(enc_i(12'd7,    5'd0, 3'd0, 5'd0,  7'h13));  // 20
    prog.push_back(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd6));       // 24
    prog.push_back(enc_i(12'd42,   5'd0, 3'd0, 5'd1,  7'h13));  // 28
    prog.push_back(enc_s(12'd8, 5'd1, 5'd0));                   // 32 sw
    prog.push_back(enc_i(12'd8,    5'd0, 3'd2, 5'd7,  7'h03));  // 36 lw
    prog.push_back(enc_i(12'd3,    5'd0, 3'd0, 5'd1,  7'h13));  // 40
    prog.push_back(enc_i(12'hFFF,  5'd1, 3'd0, 5'd1,  7'h13));  // 44 loop
    prog.push_back(enc_b(13'h1FFC, 5'd0, 5'd1, 3'd1));          // 48 bne
    prog.push_back(enc_j(21'd8, 5'd8));                         // 52 jal x8
    prog.push_back(enc_j(21'd16, 5'd0));                        // 56 -> 72
    prog.push_back(enc_i(12'd77,   5'd0, 3'd0, 5'd12, 7'h13));  // 60
    prog.push_back(enc_i(12'd0,    5'd8, 3'd0, 5'd0,  7'h67));  // 64 jalr
    prog.push_back(enc_i(12'd99,   5'd0, 3'd0, 5'd10, 7'h13));  // 68 never
    prog.push_back(enc_i(12'd1,    5'd0, 3'd0, 5'd13, 7'h13));  // 72
    load_prog();
    model_reset();

    #20;
    check("reset_pc", dut.pc, 32'd0);
    for (int k = 0; k < 32; k++) check($sformatf("reset_x%0d", k), dut.rf1.regs[k], 32'd0);
    #1 rst = 1'b1;

    run(1);
    check("first_pc", dut.pc, 32'd4);
    check("first_x1", dut.rf1.regs[1], 32'd5);
    run(4);
    check("add_x3", dut.rf1.regs[3], 32'd2);
    check("sub_x4", dut.rf1.regs[4], 32'd8);
    check("srai_x5", dut.rf1.regs[5], 32'hFFFF_FFFE);
    run(2);
    check("x0_zero", dut.rf1.regs[0], 32'd0);
    check("x6_zero", dut.rf1.regs[6], 32'd0);
    run(1);
    check("sw_bus_we", {31'd0, probe.we}, 32'd1);
    check("sw_bus_addr", {2'b00, probe.word_addr}, 32'd2);
    check("sw_bus_data", probe.wdata, 32'd42);
    run(2);
    check("sw_mem2", dut.dmem1.mem[2], 32'd42);
    check("lw_x7", dut.rf1.regs[7], 32'd42);
    run(7);
    check("loop_x1", dut.rf1.regs[1], 32'd0);
    check("loop_exit_pc", dut.pc, 32'd52);
    run(1);
    check("jal_pc", dut.pc, 32'd60);
    check("jal_x8", dut.rf1.regs[8], 32'd56);
    run(2);
    check("jalr_pc", dut.pc, 32'd56);
    check("x12", dut.rf1.regs[12], 32'd77);
    run(2);
    check("after_pc", dut.pc, 32'd76);
    check("x13", dut.rf1.regs[13], 32'd1);
    check("skip_x10", dut.rf1.regs[10], 32'd0);
    check_regs_model("directed");

    for (int k = 0; k < 32; k++) snap[k] = dut.rf1.regs[k];
    run(55);
    check("oob_pc", dut.pc, 32'd296);
    for (int k = 0; k < 32; k++) check($sformatf("oob_x%0d", k), dut.rf1.regs[k], snap[k]);

    rst = 1'b0;
    #1;
    check("midreset_pc", dut.pc, 32'd0);
    for (int k = 0; k < 32; k++) check($sformatf("midreset_x%0d", k), dut.rf1.regs[k], 32'd0);
    check("midreset_mem2", dut.dmem1.mem[2], 32'd42);
    @(posedge clk);
    #1;
    check("held_reset_pc", dut.pc, 32'd0);
    model_reset();

    for (int r = 0; r < 3; r++) begin
      prog.delete();
      for (int k = 0; k < 40; k++) prog.push_back(rand_insn());
      load_prog();
      model_reset();
      @(negedge clk) rst = 1'b1;
      run(44);
      check_regs_model($sformatf("rand%0d", r));
      for (int k = 0; k < DMEM_SIZE; k++)
        check($sformatf("rand%0d_mem%0d", r, k), dut.dmem1.mem[k], m_mem[k]);
      rst = 1'b0;
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
